// File: rtl/imul_pkg.sv
// rtl/imul_pkg.sv - shared types and request-field helpers for imul_varlat_param
package imul_pkg;

    // RISC-V multiply flavours carried in req_msg[2*NBITS+1:2*NBITS]
    typedef enum logic [1:0] {
        MODE_MUL    = 2'd0,
        MODE_MULH   = 2'd1,
        MODE_MULHSU = 2'd2,
        MODE_MULHU  = 2'd3
    } mode_e;

    // Control FSM; encoding 2'd3 is unused and treated as illegal
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // req_msg layout {mode, a, b} as functions of the operand width
    function automatic int req_msg_w(input int nbits);
        return 2 + 2 * nbits;
    endfunction

    function automatic int mode_msb(input int nbits);
        return 2 * nbits + 1;
    endfunction

    function automatic int mode_lsb(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int a_msb(input int nbits);
        return 2 * nbits - 1;
    endfunction

    function automatic int a_lsb(input int nbits);
        return nbits;
    endfunction

    function automatic int b_msb(input int nbits);
        return nbits - 1;
    endfunction

    function automatic int b_lsb(input int nbits);
        return (nbits > 0) ? 0 : 0;
    endfunction

    // Operand a is signed for MULH and MULHSU, operand b only for MULH
    function automatic logic a_is_signed(input mode_e m);
        return (m == MODE_MULH) || (m == MODE_MULHSU);
    endfunction

    function automatic logic b_is_signed(input mode_e m);
        return (m == MODE_MULH);
    endfunction

endpackage

// File: rtl/imul_ctz.sv
// rtl/imul_ctz.sv - parametrised count-trailing-zeros with all-zero flag
module imul_ctz #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Scan from the MSB down so the lowest set bit wins; all-zero reports W
    always_comb begin
        cnt = CW'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) begin
                cnt = CW'(i);
            end
        end
    end

    assign zero = (d == '0);

endmodule

// File: rtl/imul_varlat_param.sv
// rtl/imul_varlat_param.sv - iterative shift-add multiplier, IMUL_ZERO_SKIP_EN selects zero-skip stepping
module imul_varlat_param
    import imul_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int SHW   = $clog2(NBITS) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*NBITS+1:0]   req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [NBITS-1:0]     resp_msg
);

    localparam int MODE_MSB = mode_msb(NBITS);
    localparam int MODE_LSB = mode_lsb(NBITS);
    localparam int A_MSB    = a_msb(NBITS);
    localparam int A_LSB    = a_lsb(NBITS);
    localparam int B_MSB    = b_msb(NBITS);
    localparam int B_LSB    = b_lsb(NBITS);

    // Request decode
    mode_e              mode_in;
    logic [NBITS-1:0]   a_in;
    logic [NBITS-1:0]   b_in;
    logic               sign_a;
    logic               sign_b;
    logic [NBITS-1:0]   a_mag;
    logic [NBITS-1:0]   b_mag;

    assign mode_in = mode_e'(req_msg[MODE_MSB:MODE_LSB]);
    assign a_in    = req_msg[A_MSB:A_LSB];
    assign b_in    = req_msg[B_MSB:B_LSB];
    assign sign_a  = a_is_signed(mode_in) & a_in[NBITS-1];
    assign sign_b  = b_is_signed(mode_in) & b_in[NBITS-1];
    // The most-negative value negates to 2^(NBITS-1), which still fits unsigned
    assign a_mag   = sign_a ? -a_in : a_in;
    assign b_mag   = sign_b ? -b_in : b_in;

    // State
    state_e               state;
    logic [2*NBITS-1:0]   a_reg;
    logic [NBITS-1:0]     b_reg;
    logic [2*NBITS-1:0]   result;
    logic                 neg;
    mode_e                mode_r;

    logic                 req_go;
    logic                 resp_go;

    // Per-build step control
    logic [SHW-1:0]       shamt;
    logic [2*NBITS-1:0]   a_load;
    logic [NBITS-1:0]     b_load;
    logic                 calc_update;
    logic                 calc_finish;

`ifdef IMUL_ZERO_SKIP_EN
    logic [NBITS-1:0]     ctz_in;
    logic [SHW-1:0]       ctz_cnt;
    logic                 ctz_zero;

    // One ctz serves both phases: on accept it normalises |b| so B[0] is set,
    // in CALC it measures the gap to the next set bit above B[0]. That way
    // every CALC step consumes exactly one set bit plus one final B==0 step.
    assign ctz_in = (state == ST_CALC) ? (b_reg >> 1) : b_mag;

    imul_ctz #(
        .W  (NBITS),
        .CW (SHW)
    ) u_ctz (
        .d    (ctz_in),
        .cnt  (ctz_cnt),
        .zero (ctz_zero)
    );

    assign shamt       = ctz_zero ? SHW'(NBITS) : (ctz_cnt + SHW'(1));
    assign a_load      = {{NBITS{1'b0}}, a_mag} << ctz_cnt;
    assign b_load      = b_mag >> ctz_cnt;
    assign calc_finish = (b_reg == '0);
    assign calc_update = ~calc_finish;
`else
    logic [SHW-1:0]       step_cnt;

    // Fixed-latency build: one bit per cycle, exactly NBITS CALC cycles
    assign shamt       = SHW'(1);
    assign a_load      = {{NBITS{1'b0}}, a_mag};
    assign b_load      = b_mag;
    assign calc_update = 1'b1;
    assign calc_finish = (step_cnt == SHW'(NBITS - 1));

    // Step counter runs only while in CALC
    always_ff @(posedge clk) begin
        if (reset || state != ST_CALC) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + SHW'(1);
        end
    end
`endif

    assign req_go  = req_val & req_rdy;
    assign resp_go = resp_val & resp_rdy;

    // Control FSM and shift-add datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            neg    <= 1'b0;
            mode_r <= MODE_MUL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_go) begin
                        a_reg  <= a_load;
                        b_reg  <= b_load;
                        result <= '0;
                        neg    <= sign_a ^ sign_b;
                        mode_r <= mode_in;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (calc_update) begin
                        if (b_reg[0]) begin
                            result <= result + a_reg;
                        end
                        a_reg <= a_reg << shamt;
                        b_reg <= b_reg >> shamt;
                    end
                    if (calc_finish) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_go) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [2*NBITS-1:0] product;
    assign product = neg ? -result : result;

    // Handshake outputs and half selection decoded from state
    always_comb begin
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        resp_msg = (mode_r == MODE_MUL) ? product[NBITS-1:0]
                                        : product[2*NBITS-1:NBITS];
        case (state)
            ST_IDLE: begin
                req_rdy  = 1'b1;
                resp_val = 1'b0;
            end
            ST_CALC: begin
                req_rdy  = 1'b0;
                resp_val = 1'b0;
            end
            ST_DONE: begin
                req_rdy  = 1'b0;
                resp_val = 1'b1;
            end
            default: begin
                req_rdy  = 1'bx;
                resp_val = 1'bx;
                resp_msg = 'x;
            end
        endcase
    end

endmodule

// File: tb/tb_imul_varlat_param.sv
// tb/tb_imul_varlat_param.sv - self-checking bench for imul_varlat_param at NBITS=32 and NBITS=8
module tb_imul_varlat_param;

    logic        clk = 1'b0;
    logic        reset;

    logic        rv32, rr32, sv32, sr32;
    logic [65:0] m32;
    logic [31:0] o32;

    logic        rv8, rr8, sv8, sr8;
    logic [17:0] m8;
    logic [7:0]  o8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imul_varlat_param #(.NBITS(32)) u_dut32 (
        .clk      (clk),
        .reset    (reset),
        .req_val  (rv32),
        .req_rdy  (rr32),
        .req_msg  (m32),
        .resp_val (sv32),
        .resp_rdy (sr32),
        .resp_msg (o32)
    );

    imul_varlat_param #(.NBITS(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .req_val  (rv8),
        .req_rdy  (rr8),
        .req_msg  (m8),
        .resp_val (sv8),
        .resp_rdy (sr8),
        .resp_msg (o8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: extend each operand to 2n bits by its signedness, multiply, pick a half
    function automatic logic [63:0] ref_mul(input int n, input int mode, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, ea, eb, p;
        mask = (128'd1 << n) - 128'd1;
        ea = 128'(a) & mask;
        eb = 128'(b) & mask;
        if ((mode == 1 || mode == 2) && a[n-1]) ea = ea | ~mask;
        if (mode == 1 && b[n-1]) eb = eb | ~mask;
        p = ea * eb;
        if (mode == 0) return 64'(p & mask);
        return 64'((p >> n) & mask);
    endfunction

    function automatic int exp_lat(input int n, input int mode, input logic [63:0] b);
`ifdef IMUL_ZERO_SKIP_EN
        logic [63:0] mask, mag;
        mask = (64'd1 << n) - 64'd1;
        mag = b & mask;
        if (mode == 1 && b[n-1]) mag = ((64'd1 << n) - mag) & mask;
        return $countones(mag) + 2;
`else
        if (mode > 3 || b === 64'hx) return 0;
        return n + 1;
`endif
    endfunction

    function automatic logic [63:0] cur_msg(input bit sel);
        return sel ? 64'(o8) : 64'(o32);
    endfunction

    task automatic run_op(input bit sel, input int mode, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string tag);
        int n, lat;
        bit got;
        logic [63:0] exp_v, first;
        logic [1:0] m2;
        n = sel ? 8 : 32;
        m2 = 2'(mode);
        exp_v = ref_mul(n, mode, a, b);
        @(negedge clk);
        lat = 0;
        while (!(sel ? rr8 : rr32) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".req_rdy"}, 64'(sel ? rr8 : rr32), 64'd1);
        if (sel) begin
            m8 = {m2, a[7:0], b[7:0]};
            rv8 = 1'b1;
        end else begin
            m32 = {m2, a[31:0], b[31:0]};
            rv32 = 1'b1;
        end
        @(posedge clk);
        #1;
        rv8 = 1'b0;
        rv32 = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (sel ? sv8 : sv32) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk({tag, ".lat"}, got ? 64'(lat) : 64'hdead, 64'(exp_lat(n, mode, b)));
        chk({tag, ".msg"}, cur_msg(sel), exp_v);
        chk({tag, ".busy"}, 64'(sel ? rr8 : rr32), 64'd0);
        first = cur_msg(sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_val"}, 64'(sel ? sv8 : sv32), 64'd1);
            chk({tag, ".hold_msg"}, cur_msg(sel), first);
            chk({tag, ".hold_rdy"}, 64'(sel ? rr8 : rr32), 64'd0);
        end
        if (sel) sr8 = 1'b1; else sr32 = 1'b1;
        @(posedge clk);
        #1;
        sr8 = 1'b0;
        sr32 = 1'b0;
        chk({tag, ".ack_val"}, 64'(sel ? sv8 : sv32), 64'd0);
        chk({tag, ".ack_rdy"}, 64'(sel ? rr8 : rr32), 64'd1);
    endtask

    function automatic logic [63:0] pick_operand(input int n);
        logic [63:0] mask, r;
        mask = (64'd1 << n) - 64'd1;
        r = {32'($urandom), 32'($urandom)};
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return (64'd1 << (n - 1));
            3: return 64'($urandom_range(0, 15));
            default: return r & mask;
        endcase
    endfunction

    initial begin
        int stray;
        reset = 1'b1;
        rv32 = 1'b0; sr32 = 1'b0; m32 = '0;
        rv8 = 1'b0; sr8 = 1'b0; m8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.val32", 64'(sv32), 64'd0);
        chk("rst.rdy32", 64'(rr32), 64'd1);
        chk("rst.val8", 64'(sv8), 64'd0);
        chk("rst.rdy8", 64'(rr8), 64'd1);
        reset = 1'b0;

        run_op(1'b0, 0, 64'd3, 64'd4, 0, "mul_3x4");
        run_op(1'b0, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mulh_m1");
        run_op(1'b0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mul_m1");
        run_op(1'b0, 3, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mulhu_max");
        run_op(1'b0, 2, 64'hFFFFFFFE, 64'd3, 0, "mulhsu_m2x3");
        run_op(1'b0, 0, 64'h12345678, 64'd0, 0, "mul_b0");
        run_op(1'b0, 1, 64'h80000000, 64'h80000000, 0, "mulh_minmin");
        run_op(1'b0, 0, 64'd9, 64'd11, 5, "hold5");

        // Reset while CALC is running drops the transaction
        @(negedge clk);
        m32 = {2'd0, 32'd5, 32'hFFFFFFFF};
        rv32 = 1'b1;
        @(posedge clk);
        #1;
        rv32 = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.calc_val", 64'(sv32), 64'd0);
        chk("midrst.calc_rdy", 64'(rr32), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst.val", 64'(sv32), 64'd0);
        chk("midrst.rdy", 64'(rr32), 64'd1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sv32) stray++;
        end
        chk("midrst.stray", 64'(stray), 64'd0);
        run_op(1'b0, 0, 64'd7, 64'd6, 0, "mul_7x6");

        run_op(1'b1, 3, 64'hFF, 64'hFF, 0, "n8_mulhu_max");
        run_op(1'b1, 1, 64'h80, 64'hFF, 1, "n8_mulh_min");

        for (int k = 0; k < 30; k++) begin
            run_op(1'b0, int'($urandom_range(0, 3)), pick_operand(32), pick_operand(32),
                   int'($urandom_range(0, 2)), "rnd32");
        end
        for (int k = 0; k < 25; k++) begin
            run_op(1'b1, int'($urandom_range(0, 3)), pick_operand(8), pick_operand(8),
                   int'($urandom_range(0, 2)), "rnd8");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
